// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold control
// and a saturating counter of inserted load-use bubbles.
module id_ex_stage #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        id_ctrl,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [5:0]        id_funct,
    input  logic              flush,
    input  logic              ex_hold,
    output logic [9:0]        ex_ctrl,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [5:0]        ex_funct,
    output logic              stall_id,
    output logic [15:0]       bubble_cnt
);

    localparam int unsigned CTRL_W  = 10;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned CNT_W   = 16;

    // Bit positions inside {jump, aluOp[1:0], memWrite, regWrite, regDst, aluSrc, memtoReg, branch, memRead}
    localparam int unsigned CTRL_MEMREAD  = 0;
    localparam int unsigned CTRL_BRANCH   = 1;
    localparam int unsigned CTRL_REGDST   = 4;
    localparam int unsigned CTRL_MEMWRITE = 6;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CTRL_W-1:0]  ex_ctrl_q,  ex_ctrl_d;
    logic               ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0]  ex_pc4_q,   ex_pc4_d;
    logic [DATA_W-1:0]  ex_rd1_q,   ex_rd1_d;
    logic [DATA_W-1:0]  ex_rd2_q,   ex_rd2_d;
    logic [DATA_W-1:0]  ex_imm_q,   ex_imm_d;
    logic [REG_W-1:0]   ex_rs_q,    ex_rs_d;
    logic [REG_W-1:0]   ex_rt_q,    ex_rt_d;
    logic [REG_W-1:0]   ex_rd_q,    ex_rd_d;
    logic [FUNCT_W-1:0] ex_funct_q, ex_funct_d;
    logic [CNT_W-1:0]   bubble_cnt_q, bubble_cnt_d;

    logic id_uses_rt;
    logic load_use;

    // Hazard only against a valid load in EX writing a non-zero register.
    always_comb begin
        id_uses_rt = id_ctrl[CTRL_REGDST] | id_ctrl[CTRL_MEMWRITE] | id_ctrl[CTRL_BRANCH];
        load_use   = ex_valid_q & ex_ctrl_q[CTRL_MEMREAD] & (ex_rt_q != REG_W'(0)) & id_valid
                   & ((ex_rt_q == id_rs) | (id_uses_rt & (ex_rt_q == id_rt)));
        stall_id   = (load_use & ~flush) | ex_hold;
    end

    // Priority: flush, hold, load-use bubble, normal load.
    always_comb begin
        ex_ctrl_d    = ex_ctrl_q;
        ex_valid_d   = ex_valid_q;
        ex_pc4_d     = ex_pc4_q;
        ex_rd1_d     = ex_rd1_q;
        ex_rd2_d     = ex_rd2_q;
        ex_imm_d     = ex_imm_q;
        ex_rs_d      = ex_rs_q;
        ex_rt_d      = ex_rt_q;
        ex_rd_d      = ex_rd_q;
        ex_funct_d   = ex_funct_q;
        bubble_cnt_d = bubble_cnt_q;

        if (flush) begin
            ex_ctrl_d  = '0;
            ex_valid_d = 1'b0;
        end else if (ex_hold) begin
            ex_valid_d = ex_valid_q;
        end else if (load_use) begin
            ex_ctrl_d    = '0;
            ex_valid_d   = 1'b0;
            bubble_cnt_d = (bubble_cnt_q == CNT_MAX) ? bubble_cnt_q : bubble_cnt_q + CNT_W'(1);
        end else begin
            ex_ctrl_d  = id_valid ? id_ctrl : '0;
            ex_valid_d = id_valid;
            ex_pc4_d   = id_pc4;
            ex_rd1_d   = id_rd1;
            ex_rd2_d   = id_rd2;
            ex_imm_d   = id_imm;
            ex_rs_d    = id_rs;
            ex_rt_d    = id_rt;
            ex_rd_d    = id_rd;
            ex_funct_d = id_funct;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl_q    <= '0;
            ex_valid_q   <= 1'b0;
            ex_pc4_q     <= '0;
            ex_rd1_q     <= '0;
            ex_rd2_q     <= '0;
            ex_imm_q     <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_rd_q      <= '0;
            ex_funct_q   <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ex_ctrl_q    <= ex_ctrl_d;
            ex_valid_q   <= ex_valid_d;
            ex_pc4_q     <= ex_pc4_d;
            ex_rd1_q     <= ex_rd1_d;
            ex_rd2_q     <= ex_rd2_d;
            ex_imm_q     <= ex_imm_d;
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            ex_rd_q      <= ex_rd_d;
            ex_funct_q   <= ex_funct_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_ctrl    = ex_ctrl_q;
    assign ex_valid   = ex_valid_q;
    assign ex_pc4     = ex_pc4_q;
    assign ex_rd1     = ex_rd1_q;
    assign ex_rd2     = ex_rd2_q;
    assign ex_imm     = ex_imm_q;
    assign ex_rs      = ex_rs_q;
    assign ex_rt      = ex_rt_q;
    assign ex_rd      = ex_rd_q;
    assign ex_funct   = ex_funct_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: load-use bubbles, flush/hold priority,
// counter saturation and asynchronous reset.
module tb_id_ex_stage;

    localparam int unsigned DATA_W = 32;

    localparam logic [9:0] C_LW   = 10'h02D;
    localparam logic [9:0] C_ADD  = 10'h130;
    localparam logic [9:0] C_ADDI = 10'h028;
    localparam logic [9:0] C_BEQ  = 10'h082;

    logic              clk;
    logic              rst_n;
    logic [9:0]        id_ctrl;
    logic              id_valid;
    logic [DATA_W-1:0] id_pc4, id_rd1, id_rd2, id_imm;
    logic [4:0]        id_rs, id_rt, id_rd;
    logic [5:0]        id_funct;
    logic              flush, ex_hold;
    logic [9:0]        ex_ctrl;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]        ex_rs, ex_rt, ex_rd;
    logic [5:0]        ex_funct;
    logic              stall_id;
    logic [15:0]       bubble_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_cnt;

    id_ex_stage #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_ctrl(id_ctrl), .id_valid(id_valid),
        .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
        .flush(flush), .ex_hold(ex_hold),
        .ex_ctrl(ex_ctrl), .ex_valid(ex_valid),
        .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct),
        .stall_id(stall_id), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [9:0] ctrl, input logic vld, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] pc4);
        id_ctrl  = ctrl;
        id_valid = vld;
        id_rs    = rs;
        id_rt    = rt;
        id_rd    = rd;
        id_pc4   = pc4;
        id_rd1   = pc4 + 32'd1;
        id_rd2   = pc4 + 32'd2;
        id_imm   = pc4 + 32'd3;
        id_funct = 6'h20;
    endtask

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        ex_hold = 1'b0;
        set_id(10'h000, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        #2;
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_ex_ctrl", 32'(ex_ctrl), 32'd0);
        check("rst_bubble_cnt", 32'(bubble_cnt), 32'd0);
        check("rst_ex_pc4", ex_pc4, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // lw $8 followed by dependent add: one bubble
        set_id(C_LW, 1'b1, 5'd2, 5'd8, 5'd0, 32'h104);
        tick();
        check("lw_ex_ctrl", 32'(ex_ctrl), 32'(C_LW));
        check("lw_ex_rt", 32'(ex_rt), 32'd8);
        check("lw_ex_imm", ex_imm, 32'h107);
        set_id(C_ADD, 1'b1, 5'd8, 5'd9, 5'd10, 32'h108);
        #1;
        check("lu_stall_id", 32'(stall_id), 32'd1);
        tick();
        check("lu_bubble_valid", 32'(ex_valid), 32'd0);
        check("lu_bubble_ctrl", 32'(ex_ctrl), 32'd0);
        check("lu_bubble_cnt", 32'(bubble_cnt), 32'd1);
        check("lu_stall_drop", 32'(stall_id), 32'd0);
        tick();
        check("lu_add_ctrl", 32'(ex_ctrl), 32'(C_ADD));
        check("lu_add_valid", 32'(ex_valid), 32'd1);
        check("lu_add_rs", 32'(ex_rs), 32'd8);
        check("lu_add_rd", 32'(ex_rd), 32'd10);
        check("lu_add_pc4", ex_pc4, 32'h108);
        check("lu_add_funct", 32'(ex_funct), 32'h20);
        check("lu_cnt_hold", 32'(bubble_cnt), 32'd1);

        // lw $8 then addi writing $8: rt not a source, no stall
        set_id(C_LW, 1'b1, 5'd1, 5'd8, 5'd0, 32'h200);
        tick();
        set_id(C_ADDI, 1'b1, 5'd3, 5'd8, 5'd0, 32'h204);
        #1;
        check("addi_no_stall", 32'(stall_id), 32'd0);
        tick();
        check("addi_ctrl", 32'(ex_ctrl), 32'(C_ADDI));
        check("addi_rt", 32'(ex_rt), 32'd8);
        check("addi_cnt", 32'(bubble_cnt), 32'd1);

        // lw $8 then beq using rt=$8: branch reads rt, stall
        set_id(C_LW, 1'b1, 5'd1, 5'd8, 5'd0, 32'h300);
        tick();
        set_id(C_BEQ, 1'b1, 5'd4, 5'd8, 5'd0, 32'h304);
        #1;
        check("beq_stall", 32'(stall_id), 32'd1);
        tick();
        check("beq_bubble_cnt", 32'(bubble_cnt), 32'd2);
        check("beq_bubble_valid", 32'(ex_valid), 32'd0);
        tick();
        check("beq_ctrl", 32'(ex_ctrl), 32'(C_BEQ));

        // flush overrides hold
        set_id(C_ADD, 1'b1, 5'd5, 5'd6, 5'd7, 32'h400);
        flush   = 1'b1;
        ex_hold = 1'b1;
        #1;
        check("flush_hold_stall", 32'(stall_id), 32'd1);
        tick();
        check("flush_valid", 32'(ex_valid), 32'd0);
        check("flush_ctrl", 32'(ex_ctrl), 32'd0);
        flush   = 1'b0;
        ex_hold = 1'b0;

        // load-use coinciding with flush: no bubble counted
        set_id(C_LW, 1'b1, 5'd1, 5'd8, 5'd0, 32'h500);
        tick();
        set_id(C_ADD, 1'b1, 5'd8, 5'd2, 5'd3, 32'h504);
        flush = 1'b1;
        #1;
        check("lu_flush_stall", 32'(stall_id), 32'd0);
        tick();
        flush = 1'b0;
        check("lu_flush_valid", 32'(ex_valid), 32'd0);
        check("lu_flush_ctrl", 32'(ex_ctrl), 32'd0);
        check("lu_flush_cnt", 32'(bubble_cnt), 32'd2);

        // hold freezes EX for three cycles while ID changes
        set_id(C_ADD, 1'b1, 5'd5, 5'd6, 5'd7, 32'h600);
        tick();
        check("hold_pre_pc4", ex_pc4, 32'h600);
        ex_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(C_LW, 1'b1, 5'(i + 1), 5'(i + 11), 5'd0, 32'h700 + 32'(i));
            #1;
            check("hold_stall", 32'(stall_id), 32'd1);
            tick();
            check("hold_pc4", ex_pc4, 32'h600);
            check("hold_ctrl", 32'(ex_ctrl), 32'(C_ADD));
            check("hold_rs", 32'(ex_rs), 32'd5);
            check("hold_valid", 32'(ex_valid), 32'd1);
        end
        ex_hold = 1'b0;

        // invalid ID instruction loads with zeroed control
        set_id(C_ADD, 1'b0, 5'd1, 5'd2, 5'd3, 32'h800);
        tick();
        check("inv_valid", 32'(ex_valid), 32'd0);
        check("inv_ctrl", 32'(ex_ctrl), 32'd0);
        check("inv_pc4", ex_pc4, 32'h800);

        // saturation: self-dependent lw $8 chain from a near-full counter
        set_id(C_LW, 1'b1, 5'd8, 5'd8, 5'd0, 32'h900);
        tick();
        ex_hold = 1'b1;
        force dut.bubble_cnt_q = 16'hFFFC;
        tick();
        release dut.bubble_cnt_q;
        ex_hold = 1'b0;
        exp_cnt = 16'hFFFC;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
            check("sat_cnt", 32'(bubble_cnt), 32'(exp_cnt));
            check("sat_bubble_valid", 32'(ex_valid), 32'd0);
            tick();
            check("sat_reload_ctrl", 32'(ex_ctrl), 32'(C_LW));
        end
        check("sat_final", 32'(bubble_cnt), 32'hFFFF);

        // asynchronous reset between edges with valid EX contents
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(ex_valid), 32'd0);
        check("arst_ctrl", 32'(ex_ctrl), 32'd0);
        check("arst_pc4", ex_pc4, 32'd0);
        check("arst_rt", 32'(ex_rt), 32'd0);
        check("arst_cnt", 32'(bubble_cnt), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        check("post_rst_ctrl", 32'(ex_ctrl), 32'(C_LW));
        check("post_rst_pc4", ex_pc4, 32'h900);
        check("post_rst_cnt", 32'(bubble_cnt), 32'd0);

        // lw $0 then use of $0: never a hazard
        set_id(C_LW, 1'b1, 5'd1, 5'd0, 5'd0, 32'hA00);
        tick();
        set_id(C_ADD, 1'b1, 5'd0, 5'd0, 5'd4, 32'hA04);
        #1;
        check("r0_no_stall", 32'(stall_id), 32'd0);
        tick();
        check("r0_ctrl", 32'(ex_ctrl), 32'(C_ADD));
        check("r0_cnt", 32'(bubble_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
